// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT/INTT address generator.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int KYBER_PASSES = 4;
    localparam int DIL_PASSES   = 8;
    localparam int KYBER_GROUPS = 32;
    localparam int DIL_GROUPS   = 64;

    // High bit of each Kyber pass in NTT order; the bit-0 pass is the (1,0) pair insert.
    localparam logic [3:0][2:0] KYBER_PHI = {3'd1, 3'd2, 3'd4, 3'd6};

endpackage

// File: rtl/bit_insert.sv
// Inserts bit_i at position pos_i of a 7-bit value; bits at and above pos_i shift up by one.
module bit_insert (
    input  logic [6:0] val_i,
    input  logic [2:0] pos_i,
    input  logic       bit_i,
    output logic [7:0] res_o
);

    logic [7:0] pos_oh;
    logic [7:0] lo_mask;
    logic [7:0] ext;

    always_comb begin
        pos_oh  = 8'd1 << pos_i;
        lo_mask = pos_oh - 8'd1;
        ext     = {1'b0, val_i};
        res_o   = (ext & lo_mask)
                | ((ext << 1) & ~(lo_mask | pos_oh))
                | (bit_i ? pos_oh : 8'd0);
    end

endmodule

// File: rtl/ntt_address_generator.sv
// Butterfly-group index sequencer for Kyber / Dilithium NTT and INTT.
// Optional twiddle index output enabled by defining TWIDDLE_ADDR_EN.
module ntt_address_generator
    import ntt_pkg::*;
#(
    parameter int STAGE_GAP = 4,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              KD_mode,
    input  logic              intt,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              out_valid,
    output logic [ADDR_W-1:0] old_add_0,
    output logic [ADDR_W-1:0] old_add_1,
    output logic [ADDR_W-1:0] old_add_2,
    output logic [ADDR_W-1:0] old_add_3,
    output logic [2:0]        stage,
`ifdef TWIDDLE_ADDR_EN
    output logic [ADDR_W-1:0] tw_addr,
`endif
    output logic              done
);

    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

    state_e                   state_q, state_d;
    logic [2:0]               pass_q, pass_d;
    logic [5:0]               j_q, j_d;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic                     kd_q, kd_d, intt_q, intt_d;
    logic                     vld_q, vld_d, busy_q, busy_d, done_q, done_d;
    logic [3:0][ADDR_W-1:0]   add_q, add_d;
    logic [2:0]               stage_q, stage_d;
    logic                     emit;

    // In IDLE the group being computed is the first one of a transform being started.
    logic       idle;
    logic       kd_e, intt_e;
    logic [2:0] pass_c;
    logic [5:0] j_c;
    logic [2:0] last_pass;
    logic [5:0] last_j;

    assign idle      = (state_q == ST_IDLE);
    assign kd_e      = idle ? KD_mode : kd_q;
    assign intt_e    = idle ? intt    : intt_q;
    assign pass_c    = idle ? 3'd0    : pass_q;
    assign j_c       = idle ? 6'd0    : j_q;
    assign last_pass = kd_e ? 3'(DIL_PASSES - 1) : 3'(KYBER_PASSES - 1);
    assign last_j    = kd_e ? 6'(DIL_GROUPS - 1) : 6'(KYBER_GROUPS - 1);

    logic [1:0]      kidx;
    logic [2:0]      p_kyb, p_dil;
    logic [3:0][7:0] grp_addr;

    assign kidx  = intt_e ? ~pass_c[1:0] : pass_c[1:0];
    assign p_kyb = KYBER_PHI[kidx];
    assign p_dil = intt_e ? pass_c : ~pass_c;

    // Dilithium needs one insert; Kyber chains a second one to place the pair (p, p-1).
    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam logic [1:0] KB = 2'(k);
        logic [7:0] ins_a, ins_b;

        bit_insert u_ins_a (
            .val_i (kd_e ? {j_c, KB[1]} : {2'b00, j_c[4:0]}),
            .pos_i (kd_e ? p_dil : p_kyb - 3'd1),
            .bit_i (KB[0]),
            .res_o (ins_a)
        );

        bit_insert u_ins_b (
            .val_i (ins_a[6:0]),
            .pos_i (p_kyb),
            .bit_i (KB[1]),
            .res_o (ins_b)
        );

        assign grp_addr[k] = kd_e ? ins_a : ins_b;
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        j_d     = j_q;
        gap_d   = gap_q;
        kd_d    = kd_q;
        intt_d  = intt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        vld_d   = 1'b0;
        add_d   = add_q;
        stage_d = stage_q;
        emit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    kd_d    = KD_mode;
                    intt_d  = intt;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                    pass_d  = '0;
                    j_d     = '0;
                    gap_d   = '0;
                    emit    = !stall;
                end
            end
            ST_RUN: emit = !stall;
            ST_GAP: begin
                if (!stall) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_RUN;
                        pass_d  = pass_q + 3'd1;
                        j_d     = '0;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (emit) begin
            vld_d   = 1'b1;
            stage_d = pass_c;
            for (int k = 0; k < 4; k++) add_d[k] = ADDR_W'(grp_addr[k]);
            if (j_c == last_j) begin
                j_d = '0;
                if (pass_c == last_pass) begin
                    state_d = ST_DONE;
                end else if (STAGE_GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else begin
                    pass_d = pass_c + 3'd1;
                end
            end else begin
                j_d = j_c + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
            j_q     <= '0;
            gap_q   <= '0;
            kd_q    <= 1'b0;
            intt_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            add_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            j_q     <= j_d;
            gap_q   <= gap_d;
            kd_q    <= kd_d;
            intt_q  <= intt_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            add_q   <= add_d;
            stage_q <= stage_d;
        end
    end

`ifdef TWIDDLE_ADDR_EN
    // Bit position of the first layer of each Kyber pass, NTT order.
    localparam logic [3:0][2:0] KYBER_TWP = {3'd0, 3'd2, 3'd4, 3'd6};

    logic [2:0]        tw_p, tw_l;
    logic [ADDR_W-1:0] tw_q, tw_d;

    assign tw_p = kd_e ? p_dil : KYBER_TWP[kidx];
    assign tw_l = kd_e ? (3'd7 - p_dil) : (3'd6 - tw_p);
    assign tw_d = ADDR_W'((8'd1 << tw_l) + ((grp_addr[0] >> tw_p) >> 1));

    always_ff @(posedge clk) begin
        if (!rst)      tw_q <= '0;
        else if (emit) tw_q <= tw_d;
    end

    assign tw_addr = tw_q;
`endif

    assign busy      = busy_q;
    assign out_valid = vld_q;
    assign done      = done_q;
    assign stage     = stage_q;
    assign old_add_0 = add_q[0];
    assign old_add_1 = add_q[1];
    assign old_add_2 = add_q[2];
    assign old_add_3 = add_q[3];

endmodule
